input_mask_sequencer: RTL and testbench
=======================================

INPUT_MASK_SEQUENCER -- requirements
Module: input_mask_sequencer

Interface
REQ-001 SHALL have parameter VIRTUAL_NODES, default 10, number of mask entries and reservoir updates per sample.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of res_din.
REQ-003 SHALL have parameter MASK_FRAC, default 16, fractional bits of mask values.
REQ-004 SHALL have parameter SAT_MAX, default 4095, saturation ceiling for res_din.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535, watchdog limit; used only under the macro in REQ-028.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 sample_valid  input  1  input sample offered.
REQ-009 sample_data  input  16  unsigned input sample.
REQ-010 sample_ready  output  1  block accepts a sample this cycle.
REQ-011 mask_wr_en, mask_wr_addr[$clog2(VIRTUAL_NODES)-1:0], mask_wr_data[15:0]  input  mask table write port.
REQ-012 res_din  output  DATA_WIDTH  masked value driven to the downstream reservoir din.
REQ-013 res_en  output  1  one-cycle update request to the reservoir en.
REQ-014 res_valid  input  1  reservoir idle/ready (its reservoir_valid).
REQ-015 busy  output  1  sequence in progress; node_idx[$clog2(VIRTUAL_NODES)-1:0] output, current node.
REQ-016 sample_done  output  1  one-cycle pulse after the last node update of a sample completes.

Function
REQ-017 Mask table SHALL be VIRTUAL_NODES x 16-bit registers, written on mask_wr_en only while busy=0; writes while busy=1 SHALL be ignored; out-of-range addresses SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, LOAD, ISSUE, GUARD, WAIT; all outputs registered.
REQ-019 IDLE: sample_ready=1; sample_valid=1 latches sample_data, clears node_idx to 0, next LOAD; otherwise stay.
REQ-020 LOAD: res_din <= min((sample * mask[node_idx]) >> MASK_FRAC, SAT_MAX), 32-bit unsigned product, zero-extended to DATA_WIDTH; next ISSUE.
REQ-021 ISSUE: if res_valid=1, res_en=1 for exactly one cycle, next GUARD; if res_valid=0, hold in ISSUE with res_en=0.
REQ-022 GUARD: one cycle with res_en=0, res_valid ignored (reservoir drops valid after en); next WAIT.
REQ-023 WAIT: on res_valid=1, if node_idx=VIRTUAL_NODES-1 then sample_done=1 for one cycle, node_idx <= 0, next IDLE; else node_idx++, next LOAD.
REQ-024 res_din SHALL hold stable from LOAD until the next LOAD; sample_valid outside IDLE SHALL be ignored (sample_ready=0).
REQ-025 Per-node latency SHALL be 3 cycles plus reservoir completion time; sample_ready SHALL reassert the cycle after sample_done.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 On rst=0: state IDLE, sample_ready=1, res_en=0, res_din=0, busy=0, node_idx=0, sample_done=0, timeout_err=0, all mask entries 0; release is synchronous to clk.

Configuration
REQ-028 Macro MASK_SEQ_TIMEOUT_EN: when defined, a counter SHALL run in ISSUE/WAIT, clear on each state entry, and on reaching TIMEOUT_CYCLES set sticky output timeout_err (1 bit) and return to IDLE without sample_done; timeout_err clears only on reset.
REQ-029 Without MASK_SEQ_TIMEOUT_EN: no counter, timeout_err port SHALL be absent, ISSUE/WAIT wait indefinitely.

Verification
REQ-030 Reset: rst=0 mid-WAIT at node 4 -> all outputs at REQ-027 values next cycle, mask table zeroed.
REQ-031 Masks 0x8000 all nodes, sample 1000, reservoir model 5-cycle completion -> 10 res_en pulses, res_din=500 each, one sample_done, sample_ready 1 cycle later.
REQ-032 Saturation: mask 0xFFFF, sample 0xFFFF -> res_din=4095; mask 0 -> res_din=0.
REQ-033 res_valid held 0 for 20 cycles in ISSUE -> no res_en until res_valid=1, then exactly one pulse.
REQ-034 mask_wr_en during busy addr 2 data 0x1234 -> mask[2] unchanged; same write in IDLE -> next sample node 2 uses 0x1234.
REQ-035 MASK_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, res_valid stuck 0 -> timeout_err=1 at cycle 100, state IDLE, no sample_done.

Source files
------------

// File: rtl/input_mask_sequencer.sv
// Input mask sequencer: scales each accepted sample by a per-node mask and issues
// one reservoir update per virtual node. Optional watchdog: define MASK_SEQ_TIMEOUT_EN.
module input_mask_sequencer #(
  parameter int VIRTUAL_NODES  = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int MASK_FRAC      = 16,
  parameter int SAT_MAX        = 4095,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_valid,
  input  logic [15:0]                      sample_data,
  output logic                             sample_ready,
  input  logic                             mask_wr_en,
  input  logic [$clog2(VIRTUAL_NODES)-1:0] mask_wr_addr,
  input  logic [15:0]                      mask_wr_data,
  output logic [DATA_WIDTH-1:0]            res_din,
  output logic                             res_en,
  input  logic                             res_valid,
  output logic                             busy,
  output logic [$clog2(VIRTUAL_NODES)-1:0] node_idx,
  output logic                             sample_done
`ifdef MASK_SEQ_TIMEOUT_EN
  ,
  output logic                             timeout_err
`endif
);

  localparam int IDX_W = $clog2(VIRTUAL_NODES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VIRTUAL_NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_GUARD = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [15:0]             sample_r, sample_s;
  logic [15:0]             mask_r [VIRTUAL_NODES];
  logic [IDX_W-1:0]        node_s;
  logic [DATA_WIDTH-1:0]   din_s;
  logic                    en_s, done_s, ready_s;
  logic [31:0]             prod_s, scaled_s, sat_s;

  assign prod_s   = {16'd0, sample_r} * {16'd0, mask_r[node_idx]};
  assign scaled_s = prod_s >> MASK_FRAC;
  assign sat_s    = (scaled_s > 32'(SAT_MAX)) ? 32'(SAT_MAX) : scaled_s;

`ifdef MASK_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt_r;
  logic        tmo_err_s;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    sample_s = sample_r;
    node_s   = node_idx;
    din_s    = res_din;
    en_s     = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (sample_valid && sample_ready) begin
          sample_s = sample_data;
          node_s   = '0;
          state_s  = S_LOAD;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_LOAD: begin
        din_s   = DATA_WIDTH'(sat_s);
        state_s = S_ISSUE;
      end
      S_ISSUE: begin
        if (res_valid) begin
          en_s    = 1'b1;
          state_s = S_GUARD;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_GUARD: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (!res_valid) begin
          state_s = S_WAIT;
        end else if (node_idx == LAST_IDX) begin
          done_s  = 1'b1;
          node_s  = '0;
          state_s = S_IDLE;
        end else begin
          node_s  = node_idx + IDX_W'(1);
          state_s = S_LOAD;
        end
      end
      default: begin
        node_s  = '0;
        state_s = S_IDLE;
      end
    endcase
`ifdef MASK_SEQ_TIMEOUT_EN
    tmo_err_s = timeout_err;
    if ((state_r == S_ISSUE || state_r == S_WAIT) && state_s == state_r && tmo_cnt_r == TMO_LAST) begin
      tmo_err_s = 1'b1;
      en_s      = 1'b0;
      done_s    = 1'b0;
      node_s    = '0;
      state_s   = S_IDLE;
    end else begin
      tmo_err_s = timeout_err;
    end
`endif
    // The sample_done cycle is a drain cycle; new samples are taken from the next one
    ready_s = (state_s == S_IDLE) && !done_s;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      sample_r     <= 16'd0;
      node_idx     <= '0;
      res_din      <= '0;
      res_en       <= 1'b0;
      sample_done  <= 1'b0;
      sample_ready <= 1'b1;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_s;
      sample_r     <= sample_s;
      node_idx     <= node_s;
      res_din      <= din_s;
      res_en       <= en_s;
      sample_done  <= done_s;
      sample_ready <= ready_s;
      busy         <= (state_s != S_IDLE);
    end
  end

  // Mask table; writes accepted only while idle and in range
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < VIRTUAL_NODES; i++) mask_r[i] <= 16'd0;
    end else if (mask_wr_en && !busy && mask_wr_addr <= LAST_IDX) begin
      mask_r[mask_wr_addr] <= mask_wr_data;
    end else begin
      for (int i = 0; i < VIRTUAL_NODES; i++) mask_r[i] <= mask_r[i];
    end
  end

`ifdef MASK_SEQ_TIMEOUT_EN
  // Watchdog counter restarts on every state entry; error flag is sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r   <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_err_s;
      if (state_s != state_r) begin
        tmo_cnt_r <= 32'd0;
      end else if (state_r == S_ISSUE || state_r == S_WAIT) begin
        tmo_cnt_r <= tmo_cnt_r + 32'd1;
      end else begin
        tmo_cnt_r <= 32'd0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_input_mask_sequencer.sv
// Randomized self-checking bench for input_mask_sequencer with a reservoir model
// and a behavioural reference of the mask/scale/saturate rule.
module tb_input_mask_sequencer;
  localparam int VN = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = 16'd0;
  logic        sample_ready;
  logic        mask_wr_en = 1'b0;
  logic [3:0]  mask_wr_addr = 4'd0;
  logic [15:0] mask_wr_data = 16'd0;
  logic [31:0] res_din;
  logic        res_en;
  logic        res_valid = 1'b1;
  logic        busy;
  logic [3:0]  node_idx;
  logic        sample_done;

  input_mask_sequencer #(.VIRTUAL_NODES(VN)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .mask_wr_en(mask_wr_en), .mask_wr_addr(mask_wr_addr),
    .mask_wr_data(mask_wr_data), .res_din(res_din), .res_en(res_en), .res_valid(res_valid),
    .busy(busy), .node_idx(node_idx), .sample_done(sample_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int en_count = 0;
  int res_lat = 5;
  bit stall = 1'b0;
  bit prev_en = 1'b0;
  int unsigned mdl_mask [VN];
  int unsigned exp_q [$];
  int unsigned seen [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned model_din(input int unsigned s, input int unsigned m);
    longint unsigned p;
    p = (longint'(s) * longint'(m)) / 65536;
    if (p > 4095) p = 4095;
    return int'(p);
  endfunction

  // Reservoir: drops valid after an update, reports idle res_lat cycles later
  initial begin
    int rcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        res_valid = 1'b1;
        rcnt = 0;
      end else if (res_en) begin
        res_valid = 1'b0;
        rcnt = res_lat;
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) res_valid = !stall;
      end else begin
        res_valid = !stall;
      end
    end
  end

  // Update monitor
  initial begin
    forever begin
      @(negedge clk);
      if (res_en) begin
        check("en_one_cycle", 32'(prev_en), 32'd0);
        seen.push_back(res_din);
        en_count++;
      end
      prev_en = res_en;
    end
  end

  task automatic write_mask(input int a, input int unsigned d, input bit model_upd);
    mask_wr_en = 1'b1;
    mask_wr_addr = 4'(a);
    mask_wr_data = 16'(d);
    @(negedge clk);
    mask_wr_en = 1'b0;
    if (model_upd && a < VN) mdl_mask[a] = d;
  endtask

  task automatic start_sample(input int unsigned s);
    int k = 0;
    exp_q.delete();
    seen.delete();
    for (int i = 0; i < VN; i++) exp_q.push_back(model_din(s, mdl_mask[i]));
    while (!sample_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) check("ready_wait_timeout", 32'd0, 32'd1);
    sample_valid = 1'b1;
    sample_data = 16'(s);
    @(negedge clk);
    sample_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_low_busy", 32'(sample_ready), 32'd0);
  endtask

  task automatic finish_sample(input string tag);
    int k = 0;
    while (!sample_done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_ready_in_done"}, 32'(sample_ready), 32'd0);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      check({tag, "_node_in_done"}, 32'(node_idx), 32'd0);
      check({tag, "_n_updates"}, 32'(seen.size()), 32'(VN));
      for (int i = 0; i < VN && i < seen.size(); i++)
        check({tag, "_din"}, seen[i], exp_q[i]);
      @(negedge clk);
      check({tag, "_ready_after_done"}, 32'(sample_ready), 32'd1);
      check({tag, "_done_one_cycle"}, 32'(sample_done), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(sample_ready), 32'd1);
    check({tag, "_res_en"}, 32'(res_en), 32'd0);
    check({tag, "_res_din"}, res_din, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_node_idx"}, 32'(node_idx), 32'd0);
    check({tag, "_done"}, 32'(sample_done), 32'd0);
  endtask

  initial begin
    int base;
    int k;
    for (int i = 0; i < VN; i++) mdl_mask[i] = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    @(negedge clk);

    // Half-scale masks on every node
    for (int i = 0; i < VN; i++) write_mask(i, 32'h8000, 1'b1);
    res_lat = 5;
    start_sample(1000);
    finish_sample("half");

    // Saturation and zero masks
    for (int i = 0; i < VN; i++) write_mask(i, (i % 2 == 0) ? 32'hFFFF : 32'h0, 1'b1);
    start_sample(32'hFFFF);
    finish_sample("sat");

    // Random masks, samples, reservoir latency, plus ignored out-of-range writes
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < VN; i++) write_mask(i, $urandom_range(0, 65535), 1'b1);
      write_mask($urandom_range(VN, 15), $urandom_range(0, 65535), 1'b1);
      res_lat = $urandom_range(1, 6);
      start_sample($urandom_range(0, 65535));
      finish_sample("rand");
    end

    // Reservoir not ready: no update until res_valid rises, then exactly one per node
    stall = 1'b1;
    repeat (2) @(negedge clk);
    base = en_count;
    start_sample(32'h1357);
    repeat (20) @(negedge clk);
    check("stall_no_en", 32'(en_count - base), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    finish_sample("stall");

    // Mask writes ignored while busy, taken when idle
    write_mask(2, 32'h1111, 1'b1);
    start_sample(32'h4000);
    write_mask(2, 32'h1234, 1'b0);
    finish_sample("busywr");
    write_mask(2, 32'h1234, 1'b1);
    start_sample(32'h4000);
    finish_sample("idlewr");

    // Reset while waiting on the reservoir at node 4
    res_lat = 8;
    base = en_count;
    start_sample(32'hFFFF);
    k = 0;
    while (en_count < base + 5 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) check("node4_wait_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    check("pre_rst_node", 32'(node_idx), 32'd4);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b1;
    for (int i = 0; i < VN; i++) mdl_mask[i] = 0;
    res_lat = 3;
    repeat (2) @(negedge clk);
    start_sample(32'hFFFF);
    finish_sample("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
